// File: rtl/rv32_data_mem_responder_pkg.sv
// Shared types for the RV32 data memory responder.
// Request/response bundles, access sizes and FSM states.
package rv32_data_mem_responder_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } mem_size_t;

  typedef struct packed {
    logic        valid;
    logic        we;
    mem_size_t   size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
  } memory_request_t;

  typedef struct packed {
    logic        ready;
    logic        valid;
    logic [31:0] rdata;
    logic        error;
  } memory_response_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } rsp_state_t;

endpackage

// File: rtl/rv32_sram_bank.sv
// Word array with byte-enable synchronous write, comb read.
// Ports: clk, we, be[3:0], addr[AW-1:0], wdata, rdata.
module rv32_sram_bank #(
  parameter int DEPTH_WORDS = 4096,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/rv32_data_mem_responder.sv
// Single-outstanding data memory responder with fixed latency.
// Ports: clk, resetn (sync, active-low), data_request, data_response.
module rv32_data_mem_responder
  import rv32_data_mem_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  memory_request_t  data_request,
  output memory_response_t data_response
);

  localparam int AW = $clog2(DEPTH_WORDS);

  rsp_state_t      state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  memory_request_t req_q, req_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    case (state_q)
      IDLE: begin
        if (data_request.valid) begin
          req_d = data_request;
          if (WAIT_CYCLES > 0) begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end else begin
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else cnt_d = cnt_q - 4'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (!resetn) begin
      state_d = IDLE;
      cnt_d   = '0;
      req_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
    req_q   <= req_d;
  end

  logic [31:0] idx;
  logic        oor;
  logic        mis;
  logic        err;
  logic [3:0]  be;
  logic [31:0] wd;
  logic [31:0] rd_word;
  logic [31:0] sh;
  logic [31:0] rd_ext;
  logic        mem_we;

  always_comb begin
    idx = (req_q.addr - BASE_ADDR) >> 2;
    oor = (req_q.addr < BASE_ADDR) || (idx >= 32'(DEPTH_WORDS));
    mis = 1'b1;
    be  = 4'b0000;
    wd  = req_q.wdata;
    case (req_q.size)
      BYTE: begin
        mis = 1'b0;
        be  = 4'b0001 << req_q.addr[1:0];
        wd  = {4{req_q.wdata[7:0]}};
      end
      HALF: begin
        mis = req_q.addr[0];
        be  = req_q.addr[1] ? 4'b1100 : 4'b0011;
        wd  = {2{req_q.wdata[15:0]}};
      end
      WORD: begin
        mis = (req_q.addr[1:0] != 2'b00);
        be  = 4'b1111;
      end
      default: mis = 1'b1;
    endcase
    err = oor | mis;
  end

  // Write lands on the edge leaving RESP; a reset edge cancels it.
  assign mem_we = (state_q == RESP) && req_q.we && !err && resetn;

  rv32_sram_bank #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_bank (
    .clk  (clk),
    .we   (mem_we),
    .be   (be),
    .addr (idx[AW-1:0]),
    .wdata(wd),
    .rdata(rd_word)
  );

  always_comb begin
    sh     = rd_word >> {req_q.addr[1:0], 3'b000};
    rd_ext = sh;
    case (req_q.size)
      BYTE: rd_ext = req_q.sign_ext ? {{24{sh[7]}}, sh[7:0]}
                                    : {24'b0, sh[7:0]};
      HALF: rd_ext = req_q.sign_ext ? {{16{sh[15]}}, sh[15:0]}
                                    : {16'b0, sh[15:0]};
      default: rd_ext = sh;
    endcase
  end

  always_comb begin
    data_response.ready = (state_q == IDLE);
    data_response.valid = (state_q == RESP);
    data_response.error = data_response.valid & err;
    data_response.rdata = '0;
    if (data_response.valid && !err && !req_q.we)
      data_response.rdata = rd_ext;
  end

endmodule

// File: tb/tb_rv32_data_mem_responder.sv
// Directed scoreboard bench for rv32_data_mem_responder.
// Unit 0 uses WAIT_CYCLES=1, unit 1 uses WAIT_CYCLES=0.
module tb_rv32_data_mem_responder;
  import rv32_data_mem_responder_pkg::*;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  memory_request_t  req [2];
  memory_response_t rsp [2];

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sbq [$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  rv32_data_mem_responder #(
    .DEPTH_WORDS(4096),
    .BASE_ADDR  (32'h0),
    .WAIT_CYCLES(1)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .data_request (req[0]),
    .data_response(rsp[0])
  );

  rv32_data_mem_responder #(
    .DEPTH_WORDS(16),
    .BASE_ADDR  (32'h0),
    .WAIT_CYCLES(0)
  ) dut0 (
    .clk          (clk),
    .resetn       (resetn),
    .data_request (req[1]),
    .data_response(rsp[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic xact(input int u, input logic we, input mem_size_t sz,
                      input logic sx, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] exp_rd,
                      input logic exp_err, input string tag);
    exp_t e;
    int   k;
    e.tag   = tag;
    e.rdata = exp_rd;
    e.err   = exp_err;
    e.lat   = (u == 1) ? 1 : 2;
    sbq.push_back(e);
    @(negedge clk);
    req[u].valid    = 1'b1;
    req[u].we       = we;
    req[u].size     = sz;
    req[u].sign_ext = sx;
    req[u].addr     = a;
    req[u].wdata    = wd;
    k = 0;
    while (rsp[u].ready !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_rdy"}, 32'(k < 20), 32'd1);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (rsp[u].valid !== 1'b1 && k < 20);
    e = sbq.pop_front();
    chk({e.tag, "_valid"}, 32'(rsp[u].valid), 32'd1);
    chk({e.tag, "_lat"}, 32'(k), 32'(e.lat));
    chk({e.tag, "_rdata"}, rsp[u].rdata, e.rdata);
    chk({e.tag, "_err"}, 32'(rsp[u].error), 32'(e.err));
    req[u].valid = 1'b0;
    @(negedge clk);
    chk({e.tag, "_after"}, {30'b0, rsp[u].ready, rsp[u].valid}, 32'd2);
  endtask

  initial begin
    memory_response_t rst_exp;
    req[0] = '0;
    req[1] = '0;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    rst_exp = '0;
    rst_exp.ready = 1'b1;
    chk("reset_rsp0", 32'(rsp[0]), 32'(rst_exp));
    chk("reset_rsp1", 32'(rsp[1]), 32'(rst_exp));

    xact(0, 1, WORD, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, "wr_w10");
    xact(0, 0, WORD, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, "rd_w10");
    xact(0, 1, BYTE, 0, 32'h13, 32'h80, 32'h0, 0, "wr_b13");
    xact(0, 0, BYTE, 1, 32'h13, 32'h0, 32'hFFFFFF80, 0, "rd_b13s");
    xact(0, 0, BYTE, 0, 32'h13, 32'h0, 32'h00000080, 0, "rd_b13z");
    xact(0, 0, WORD, 0, 32'h10, 32'h0, 32'h80ADBEEF, 0, "rd_w10b");
    xact(0, 0, HALF, 1, 32'h12, 32'h0, 32'hFFFF80AD, 0, "rd_h12s");
    xact(0, 0, HALF, 1, 32'h10, 32'h0, 32'hFFFFBEEF, 0, "rd_h10s");
    xact(0, 0, HALF, 0, 32'h10, 32'h0, 32'h0000BEEF, 0, "rd_h10z");
    xact(0, 0, HALF, 0, 32'h11, 32'h0, 32'h0, 1, "mis_h11");
    xact(0, 1, WORD, 0, 32'h12, 32'h12345678, 32'h0, 1, "mis_w12");
    xact(0, 0, WORD, 0, 32'h10, 32'h0, 32'h80ADBEEF, 0, "rd_w10c");
    xact(0, 1, HALF, 0, 32'h12, 32'h00005A5A, 32'h0, 0, "wr_h12");
    xact(0, 0, WORD, 0, 32'h10, 32'h0, 32'h5A5ABEEF, 0, "rd_w10d");
    xact(0, 0, WORD, 0, 32'h4000, 32'h0, 32'h0, 1, "oor_4000");
    xact(0, 1, WORD, 0, 32'h3FFC, 32'hA5A50001, 32'h0, 0, "wr_3ffc");
    xact(0, 0, WORD, 0, 32'h3FFC, 32'h0, 32'hA5A50001, 0, "rd_3ffc");

    xact(0, 1, WORD, 0, 32'h20, 32'hCAFEF00D, 32'h0, 0, "wr_w20");
    @(negedge clk);
    req[0].valid    = 1'b1;
    req[0].we       = 1'b1;
    req[0].size     = WORD;
    req[0].sign_ext = 1'b0;
    req[0].addr     = 32'h20;
    req[0].wdata    = 32'h11111111;
    @(negedge clk);
    chk("abort_in_wait", 32'(rsp[0].ready), 32'd0);
    resetn       = 1'b0;
    req[0].valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("abort_novalid", 32'(rsp[0].valid), 32'd0);
      @(negedge clk);
    end
    xact(0, 0, WORD, 0, 32'h20, 32'h0, 32'hCAFEF00D, 0, "rd_w20");

    xact(1, 1, WORD, 0, 32'h4, 32'h0000_55AA, 32'h0, 0, "w0_wr");
    xact(1, 0, WORD, 0, 32'h4, 32'h0, 32'h0000_55AA, 0, "w0_rd");
    xact(1, 0, WORD, 0, 32'h40, 32'h0, 32'h0, 1, "w0_oor");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
